// File: rtl/anim_pkg.sv
// Shared state encoding and sprite-select codes for the player animation controller
// and the sprite mux that decodes its output.
package anim_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WALK,
    JUMP,
    ATTACK
  } anim_state_t;

  localparam logic [3:0] SEL_IDLE_R = 4'd0;
  localparam logic [3:0] SEL_IDLE_L = 4'd1;
  localparam logic [3:0] SEL_WALK_R = 4'd2;
  localparam logic [3:0] SEL_WALK_L = 4'd3;
  localparam logic [3:0] SEL_JUMP_R = 4'd4;
  localparam logic [3:0] SEL_JUMP_L = 4'd5;
  localparam logic [3:0] SEL_ATTACK = 4'd6;

  localparam logic [1:0] FRAME_LAST = 2'd3;

  // Facing adds one to the right-facing base code; ATTACK is direction-agnostic.
  function automatic logic [3:0] sel_code(input anim_state_t st, input logic facing_left);
    logic [3:0] base;
    case (st)
      IDLE:    base = SEL_IDLE_R;
      WALK:    base = SEL_WALK_R;
      JUMP:    base = SEL_JUMP_R;
      default: return SEL_ATTACK;
    endcase
    return base + {3'b000, facing_left};
  endfunction

endpackage

// File: rtl/anim_step_counter.sv
// Sub-frame sequencer: divides frame ticks by STEP_TICKS and advances a 2-bit frame
// index that either wraps (walk cycle) or saturates (attack).
module anim_step_counter
  import anim_pkg::*;
#(
  parameter int unsigned STEP_TICKS = 6
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_clear,
  input  logic       i_enable,
  input  logic       i_saturate_mode,
  output logic [1:0] o_frame
);

  localparam int unsigned SW = (STEP_TICKS > 1) ? $clog2(STEP_TICKS) : 1;
  localparam logic [SW-1:0] STEP_LAST = SW'(STEP_TICKS - 1);

  logic [SW-1:0] r_step;
  logic [1:0]    r_frame;

  always_ff @(posedge i_clk) begin
    if (i_reset || i_clear) begin
      r_step  <= '0;
      r_frame <= '0;
    end else if (i_enable) begin
      if (r_step == STEP_LAST) begin
        r_step <= '0;
        if (!(i_saturate_mode && r_frame == FRAME_LAST)) begin
          r_frame <= r_frame + 2'd1;
        end
      end else begin
        r_step <= r_step + 1'b1;
      end
    end
  end

  assign o_frame = r_frame;

endmodule

// File: rtl/anim_state_ctrl.sv
// Player animation FSM: turns key/physics inputs into sprite select, sub-frame index
// and facing, advancing once per video frame tick.
module anim_state_ctrl
  import anim_pkg::*;
#(
  parameter int unsigned STEP_TICKS   = 6,
  parameter int unsigned ATTACK_TICKS = 16,
  parameter int unsigned CNT_W        = 5
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_tick,
  input  logic       key_left,
  input  logic       key_right,
  input  logic       key_jump,
  input  logic       key_attack,
  input  logic       on_ground,
  output logic [3:0] sprite_sel,
  output logic [1:0] anim_frame,
  output logic       facing_left,
  output logic       busy
);

  localparam logic [CNT_W-1:0] ATTACK_LAST = CNT_W'(ATTACK_TICKS - 1);

  anim_state_t      r_state;
  logic             r_facing;
  logic [CNT_W-1:0] r_tick_cnt;
  logic [3:0]       r_sel;
  logic             r_busy;

  anim_state_t w_state_d;
  logic        w_facing_d;
  logic        w_dir_valid;
  logic        w_state_chg;
  logic        w_anim_restart;

  always_comb begin
    w_dir_valid = key_left ^ key_right;
    w_state_d   = r_state;
    unique case (r_state)
      IDLE, WALK: begin
        if (key_attack)                w_state_d = ATTACK;
        else if (key_jump && on_ground) w_state_d = JUMP;
        else if (w_dir_valid)          w_state_d = WALK;
        else                           w_state_d = IDLE;
      end
      JUMP: begin
        // The tick_cnt guard forces at least one airborne tick.
        if (on_ground && r_tick_cnt != '0) w_state_d = w_dir_valid ? WALK : IDLE;
      end
      ATTACK: begin
        if (r_tick_cnt == ATTACK_LAST) w_state_d = w_dir_valid ? WALK : IDLE;
      end
    endcase

    w_facing_d = r_facing;
    if (r_state != ATTACK && w_dir_valid) w_facing_d = key_left;

    w_state_chg    = (w_state_d != r_state);
    // A direction flip mid-walk restarts the walk cycle for the new sprite.
    w_anim_restart = w_state_chg || (w_facing_d != r_facing);
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state    <= IDLE;
      r_facing   <= 1'b0;
      r_tick_cnt <= '0;
      r_sel      <= SEL_IDLE_R;
      r_busy     <= 1'b0;
    end else if (frame_tick) begin
      r_state  <= w_state_d;
      r_facing <= w_facing_d;
      if (w_state_chg)            r_tick_cnt <= '0;
      else if (r_tick_cnt != '1)  r_tick_cnt <= r_tick_cnt + 1'b1;
      r_sel  <= sel_code(w_state_d, w_facing_d);
      r_busy <= (w_state_d == JUMP) || (w_state_d == ATTACK);
    end
  end

  anim_step_counter #(
    .STEP_TICKS(STEP_TICKS)
  ) u_step (
    .i_clk          (Clk),
    .i_reset        (Reset),
    .i_clear        (frame_tick && w_anim_restart),
    .i_enable       (frame_tick && (r_state == WALK || r_state == ATTACK)),
    .i_saturate_mode(r_state == ATTACK),
    .o_frame        (anim_frame)
  );

  assign sprite_sel  = r_sel;
  assign facing_left = r_facing;
  assign busy        = r_busy;

endmodule

// File: tb/tb_anim_state_ctrl.sv
// Directed bench for anim_state_ctrl with STEP_TICKS=2, ATTACK_TICKS=4.
module tb_anim_state_ctrl;

  logic       Clk = 1'b0;
  logic       Reset;
  logic       frame_tick;
  logic       key_left, key_right, key_jump, key_attack, on_ground;
  logic [3:0] sprite_sel;
  logic [1:0] anim_frame;
  logic       facing_left;
  logic       busy;

  int n_cmp = 0;
  int n_bad = 0;

  // keys packed as {left, right, jump, attack, on_ground}
  typedef struct {
    logic [4:0] keys;
    logic [3:0] sel;
    logic [1:0] frm;
    logic       fl;
    logic       bsy;
  } vec_t;

  vec_t vecs[$];

  always #5 Clk = ~Clk;

  anim_state_ctrl #(
    .STEP_TICKS  (2),
    .ATTACK_TICKS(4),
    .CNT_W       (5)
  ) dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .frame_tick (frame_tick),
    .key_left   (key_left),
    .key_right  (key_right),
    .key_jump   (key_jump),
    .key_attack (key_attack),
    .on_ground  (on_ground),
    .sprite_sel (sprite_sel),
    .anim_frame (anim_frame),
    .facing_left(facing_left),
    .busy       (busy)
  );

  function automatic vec_t mk(input logic [4:0] keys, input logic [3:0] sel,
                              input logic [1:0] frm, input logic fl, input logic bsy);
    vec_t v;
    v.keys = keys;
    v.sel  = sel;
    v.frm  = frm;
    v.fl   = fl;
    v.bsy  = bsy;
    return v;
  endfunction

  task automatic check(input string name, input logic [3:0] sel, input logic [1:0] frm,
                       input logic fl, input logic bsy);
    n_cmp++;
    if ({sprite_sel, anim_frame, facing_left, busy} !== {sel, frm, fl, bsy}) begin
      n_bad++;
      $display("FAIL %s: got sel=%0d frame=%0d facing_left=%0b busy=%0b, want sel=%0d frame=%0d facing_left=%0b busy=%0b",
               name, sprite_sel, anim_frame, facing_left, busy, sel, frm, fl, bsy);
    end
  endtask

  // Drive inputs on the falling edge, let one rising edge occur, sample 1 time unit later.
  task automatic apply(input logic [4:0] keys, input logic ft, input logic rst);
    @(negedge Clk);
    {key_left, key_right, key_jump, key_attack, on_ground} = keys;
    frame_tick = ft;
    Reset      = rst;
    @(posedge Clk);
    #1;
    frame_tick = 1'b0;
    Reset      = 1'b0;
  endtask

  initial begin
    Reset = 1'b1;
    frame_tick = 1'b0;
    {key_left, key_right, key_jump, key_attack, on_ground} = 5'b00001;

    apply(5'b00001, 1'b1, 1'b1);
    check("reset", 4'd0, 2'd0, 1'b0, 1'b0);

    // idle
    repeat (3) vecs.push_back(mk(5'b00001, 4'd0, 2'd0, 1'b0, 1'b0));
    // walk right, frame advances every 2 ticks
    vecs.push_back(mk(5'b01001, 4'd2, 2'd0, 1'b0, 1'b0));
    vecs.push_back(mk(5'b01001, 4'd2, 2'd0, 1'b0, 1'b0));
    vecs.push_back(mk(5'b01001, 4'd2, 2'd1, 1'b0, 1'b0));
    vecs.push_back(mk(5'b01001, 4'd2, 2'd1, 1'b0, 1'b0));
    vecs.push_back(mk(5'b01001, 4'd2, 2'd2, 1'b0, 1'b0));
    vecs.push_back(mk(5'b01001, 4'd2, 2'd2, 1'b0, 1'b0));
    // turn left: walk cycle restarts
    vecs.push_back(mk(5'b10001, 4'd3, 2'd0, 1'b1, 1'b0));
    vecs.push_back(mk(5'b10001, 4'd3, 2'd0, 1'b1, 1'b0));
    // idle left, grounded jump, exit on 2nd tick after entry
    vecs.push_back(mk(5'b00001, 4'd1, 2'd0, 1'b1, 1'b0));
    vecs.push_back(mk(5'b00101, 4'd5, 2'd0, 1'b1, 1'b1));
    vecs.push_back(mk(5'b00001, 4'd5, 2'd0, 1'b1, 1'b1));
    vecs.push_back(mk(5'b00001, 4'd1, 2'd0, 1'b1, 1'b0));
    // jump, then airborne for 5 ticks, land
    vecs.push_back(mk(5'b00101, 4'd5, 2'd0, 1'b1, 1'b1));
    repeat (5) vecs.push_back(mk(5'b00000, 4'd5, 2'd0, 1'b1, 1'b1));
    vecs.push_back(mk(5'b00001, 4'd1, 2'd0, 1'b1, 1'b0));
    // walk right, attack 4 ticks with left key ignored, exit to walk right
    vecs.push_back(mk(5'b01001, 4'd2, 2'd0, 1'b0, 1'b0));
    vecs.push_back(mk(5'b01011, 4'd6, 2'd0, 1'b0, 1'b1));
    vecs.push_back(mk(5'b10001, 4'd6, 2'd0, 1'b0, 1'b1));
    vecs.push_back(mk(5'b10001, 4'd6, 2'd1, 1'b0, 1'b1));
    vecs.push_back(mk(5'b01011, 4'd6, 2'd1, 1'b0, 1'b1));
    vecs.push_back(mk(5'b01001, 4'd2, 2'd0, 1'b0, 1'b0));
    // walk left, then both keys: idle, facing kept
    vecs.push_back(mk(5'b10001, 4'd3, 2'd0, 1'b1, 1'b0));
    vecs.push_back(mk(5'b11001, 4'd1, 2'd0, 1'b1, 1'b0));

    foreach (vecs[i]) begin
      apply(vecs[i].keys, 1'b1, 1'b0);
      check($sformatf("vec%0d", i), vecs[i].sel, vecs[i].frm, vecs[i].fl, vecs[i].bsy);
    end

    // Keys change without frame_tick: nothing moves.
    begin
      logic [4:0] noise [4];
      noise[0] = 5'b01010;
      noise[1] = 5'b00101;
      noise[2] = 5'b01001;
      noise[3] = 5'b10110;
      for (int k = 0; k < 4; k++) begin
        apply(noise[k], 1'b0, 1'b0);
        check($sformatf("hold%0d", k), 4'd1, 2'd0, 1'b1, 1'b0);
      end
    end

    // Reset on ATTACK tick 2, coinciding with a frame_tick.
    apply(5'b00011, 1'b1, 1'b0);
    check("atk_a_entry", 4'd6, 2'd0, 1'b1, 1'b1);
    apply(5'b00001, 1'b1, 1'b0);
    check("atk_a_t1", 4'd6, 2'd0, 1'b1, 1'b1);
    apply(5'b00011, 1'b1, 1'b1);
    check("atk_reset", 4'd0, 2'd0, 1'b0, 1'b0);

    // A fresh attack must last the full 4 ticks (no leftover tick count).
    apply(5'b00011, 1'b1, 1'b0);
    check("atk_b_t0", 4'd6, 2'd0, 1'b0, 1'b1);
    apply(5'b00001, 1'b1, 1'b0);
    check("atk_b_t1", 4'd6, 2'd0, 1'b0, 1'b1);
    apply(5'b00001, 1'b1, 1'b0);
    check("atk_b_t2", 4'd6, 2'd1, 1'b0, 1'b1);
    apply(5'b00001, 1'b1, 1'b0);
    check("atk_b_t3", 4'd6, 2'd1, 1'b0, 1'b1);
    apply(5'b00001, 1'b1, 1'b0);
    check("atk_b_exit", 4'd0, 2'd0, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/anim_state_ctrl.md
Name: anim_state_ctrl

Overview:
- Animation controller that generates the 4-bit sprite select for the player sprite mux, plus a walk/attack sub-frame index and a facing bit.
- Sits between the keyboard/physics logic and the sprite mux; all state advances once per video frame on `frame_tick`.
- Sprite select codes, fixed and shared with the mux:
  - 0 IdleR, 1 IdleL
  - 2 WalkR, 3 WalkL
  - 4 JumpR, 5 JumpL
  - 6 Attack (direction-agnostic)

Parameters:
- STEP_TICKS, 6, frame_ticks per `anim_frame` advance in WALK/ATTACK (≥1).
- ATTACK_TICKS, 16, frame_ticks spent in ATTACK before exit (≥1).
- CNT_W, 5, width of the internal tick counter; must hold max(STEP_TICKS, ATTACK_TICKS).

Ports:
- Clk  in  1  system clock; the only clock.
- Reset  in  1  synchronous, active-high reset.
- frame_tick  in  1  one-Clk pulse per video frame (vsync-derived).
- key_left  in  1  left key held.
- key_right  in  1  right key held.
- key_jump  in  1  jump key held.
- key_attack  in  1  attack (roll) key held.
- on_ground  in  1  physics reports the sprite is resting on ground.
- sprite_sel  out  4  select code to the sprite mux.
- anim_frame  out  2  sub-frame index within the current animation.
- facing_left  out  1  0 = right, 1 = left.
- busy  out  1  high in JUMP or ATTACK.

Behaviour:
- Reset (synchronous, sampled on Clk rising edge):
  - state=IDLE, facing_left=0, sprite_sel=0, anim_frame=0, busy=0.
  - tick_cnt=0, step_cnt=0.
  - Reset overrides frame_tick on the same edge.
- Update timing:
  - All outputs are registered.
  - Inputs are evaluated only on Clk edges where frame_tick=1; new outputs appear on that edge (visible the cycle after the tick).
  - When frame_tick=0, all state holds regardless of inputs.
- Direction decode:
  - dir_valid = key_left XOR key_right.
  - Both keys held or neither: no walk request; facing unchanged.
- States: IDLE, WALK, JUMP, ATTACK. On each tick, priority is ATTACK > JUMP > WALK > IDLE.
  - IDLE/WALK:
    - key_attack → ATTACK.
    - Else key_jump & on_ground → JUMP.
    - Else dir_valid → WALK.
    - Else → IDLE.
  - JUMP:
    - Remains until a tick with on_ground=1 and tick_cnt≥1. This guarantees at least one tick airborne even if on_ground never drops.
    - On exit, go to WALK if dir_valid, else IDLE. Jump and attack keys are ignored in JUMP.
  - ATTACK:
    - Stays exactly ATTACK_TICKS ticks, counted from the entry tick as tick 0.
    - On the tick where tick_cnt = ATTACK_TICKS-1, exit to WALK if dir_valid, else IDLE.
    - All keys are ignored until then; facing is frozen.
- Facing:
  - Updated on a tick in IDLE, WALK or JUMP when dir_valid: facing_left=key_left.
  - The update applies in the same tick as the state change, so sprite_sel uses the new facing.
- Counters:
  - tick_cnt clears to 0 on every state change; otherwise it increments per tick, saturating at its max.
  - step_cnt clears on state change; in WALK/ATTACK it counts 0..STEP_TICKS-1 and wraps.
- anim_frame:
  - Clears to 0 on any state change; stays 0 in IDLE and JUMP.
  - WALK: increments on each step_cnt wrap, 3→0 wrap-around.
  - ATTACK: same increment, but saturates at 3.
- sprite_sel = base code + facing_left, where base is IDLE=0, WALK=2, JUMP=4.
  - ATTACK outputs 6 regardless of facing.
  - Codes 7–15 are never produced.
- busy = (state==JUMP) | (state==ATTACK).
- Reset mid-JUMP or mid-ATTACK: next cycle IDLE, outputs 0, no residual counts.

Decomposition:
- Package `anim_pkg` holds:
  - The `anim_state_t` enum (IDLE, WALK, JUMP, ATTACK).
  - 4-bit localparams SEL_IDLE_R=0, SEL_IDLE_L=1, SEL_WALK_R=2, SEL_WALK_L=3, SEL_JUMP_R=4, SEL_JUMP_L=5, SEL_ATTACK=6. The sprite mux decodes against the same constants.
- One sub-module, `anim_step_counter`:
  - Contains the step_cnt and anim_frame logic.
  - Inputs: clear, enable, saturate_mode.
  - Output: the 2-bit frame.
  - Parameterised by STEP_TICKS.

Test Plan (STEP_TICKS=2, ATTACK_TICKS=4 unless stated):
1. Reset, then 3 ticks with no keys → sprite_sel=0, anim_frame=0, facing_left=0, busy=0 throughout.
2. Hold key_right for 6 ticks → sprite_sel=2 from the 1st tick; anim_frame sequence 0,0,1,1,2,2. Switch to key_left → sprite_sel=3, anim_frame=0, facing_left=1.
3. In IDLE facing left, key_jump with on_ground=1 → sprite_sel=5, busy=1. Hold on_ground=1 → exits to sprite_sel=1 on the 2nd tick. Hold on_ground=0 for 5 ticks → stays 5.
4. key_attack from WALK-right → sprite_sel=6 for exactly 4 ticks; anim_frame 0,0,1,1. Toggling key_left during ATTACK leaves facing_left=0. On the 5th tick with key_right held → sprite_sel=2.
5. key_left and key_right both held from WALK-left → sprite_sel=1 (IDLE, facing kept). Keys toggled between ticks with frame_tick=0 → no output change.
6. Assert Reset during ATTACK tick 2 → the next cycle shows sprite_sel=0, anim_frame=0, busy=0. A following key_attack gives a full 4-tick attack.
